np_dbg_bridge: RTL and testbench
================================

# np_dbg_bridge

Debug bridge that turns command frames on a dedicated 8N1 serial line into word transactions on the iomem bus. It acts as an iomem initiator, driving `valid`/`addr`/`wdata`/`wstrb` and waiting for `ready`/`rdata` from peripheral responders such as the gpio controller. Each frame returns a status or data reply on the serial TX line. It sits beside the CPU at the top level, behind the iomem arbiter, so registers can be poked while the core is halted or held in reset.

## Interface
- `CLK_DIV`, 104: core_clock cycles per serial bit; legal range 8..65535.
- `BUS_TIMEOUT`, 255: maximum cycles to wait for `m_ready` before the transaction is abandoned.
- `FRAME_GAP`, 65535: maximum idle cycles between bytes of one frame before the parser resynchronises.
- `core_clock`  in  1  system clock.
- `RST`  in  1  reset, synchronous, active-low.
- `dbg_rx`  in  1  serial input, asynchronous, idle high.
- `dbg_tx`  out  1  serial output, idle high.
- `m_valid`  out  1  iomem request.
- `m_ready`  in  1  iomem responder completion; one-cycle pulse.
- `m_wstrb`  out  4  byte strobes; 4'hF for a write, 4'h0 for a read.
- `m_addr`  out  32  word address.
- `m_wdata`  out  32  write data.
- `m_rdata`  in  32  read data; valid in the cycle `m_ready`=1.
- `busy`  out  1  high from the first byte of a frame until the last reply bit has been sent.

## Operation
- Serial format (RX and TX): 8N1, LSB first.
  - RX: `dbg_rx` passes through a 2-FF synchroniser. A start bit is confirmed by re-sampling at CLK_DIV/2; data bits are sampled at mid-bit.
  - Framing error (stop bit sampled 0): the byte is discarded and the parser returns to IDLE.
- Frame formats; all multi-byte fields are MSB first.
  - Write: 0x57 'W', then addr[4], then data[4]. Reply: 0x4B 'K'.
  - Read: 0x52 'R', then addr[4]. Reply: rdata[4].
  - Bus timeout: single reply byte 0x54 'T' for both commands.
  - Any other command byte is silently dropped; the parser stays in IDLE.
- States:
  - IDLE: a 'W' or 'R' byte goes to ADDR, with the byte counter cleared.
  - ADDR: shifts 4 bytes into `m_addr`. Then goes to DATA for 'W' or BUS for 'R'.
  - DATA: shifts 4 bytes into `m_wdata`, then goes to BUS.
  - BUS: `m_valid`=1 and the timeout counter runs. `m_ready`=1 latches `m_rdata` (read) and goes to RESP. Counter reaching BUS_TIMEOUT goes to RESP with the 'T' reply.
  - RESP: sends 1 or 4 bytes, then returns to IDLE.
- Inter-byte gap: in ADDR or DATA, FRAME_GAP cycles without a completed byte returns to IDLE with no bus cycle and no reply.
- No buffering: bytes completing during BUS or RESP are dropped.
- Counters:
  - Bit-timing counter is 16-bit; timeout counters are sized by $clog2 of their parameter.
  - No counter wraps; each saturates or reloads on state entry.

## Timing
- Reset values: `dbg_tx`=1, `m_valid`=0, `m_wstrb`=0, `m_addr`=0, `m_wdata`=0, `busy`=0, state IDLE.
- RX byte strobe fires in the cycle the stop bit is sampled (mid stop bit).
- `m_valid` rises 1 cycle after the strobe of the last frame byte.
- `m_addr`, `m_wdata` and `m_wstrb` are stable for the whole time `m_valid`=1.
- The cycle that samples `m_ready`=1 at a posedge makes `m_valid` 0 in the next cycle. The bridge never re-asserts in that cycle.
- Timeout: `m_valid` falls exactly BUS_TIMEOUT cycles after it rose. A `m_ready` arriving in the same cycle as expiry wins: the transaction completes normally.
- First reply start bit begins 1 cycle after leaving BUS. Reply bytes are back-to-back, each 10·CLK_DIV cycles.
- `busy` falls 1 cycle after the last stop bit completes.
- Reset mid-operation (RST=0 at any posedge): all state and outputs return to reset values next cycle. A TX frame in progress is truncated with the line high; `m_valid` is dropped without waiting for `m_ready`.

## Structure
- Package `np_dbg_pkg`:
  - command/reply constants 0x57, 0x52, 0x4B, 0x54;
  - parser state enum (IDLE, ADDR, DATA, BUS, RESP).
- Sub-module `np_uart_phy`: RX and TX byte engines sharing CLK_DIV. Interface is a byte strobe plus framing-error flag on RX, and a load/ready handshake on TX.
- `np_dbg_bridge` holds the frame parser, bus FSM and reply sequencer.

## Test plan
- Write: CLK_DIV=8, send 'W' 03000000 000000A5; responder acks after 2 cycles.
  - Expect one `m_valid` burst with addr 0x03000000, wdata 0x000000A5, wstrb 4'hF.
  - Expect reply 0x4B.
- Read: responder returns 0xDEADBEEF, send 'R' 03000000.
  - Expect wstrb 4'h0 and reply bytes DE AD BE EF.
- Timeout: BUS_TIMEOUT=16, responder never acks.
  - Expect `m_valid` high for exactly 16 cycles and reply 0x54.
- Ready at expiry: `m_ready` pulsed in the expiry cycle.
  - Expect a normal completion ('K' or data), not 'T'.
- Bad input, all with `m_valid` never asserting:
  - byte 0x41: no reply;
  - stop bit forced 0 in the second address byte: no reply, parser back in IDLE;
  - gap > FRAME_GAP after 2 address bytes: no reply.
- Reset: RST=0 for 1 cycle during BUS and again mid reply byte.
  - Expect all outputs at reset values next cycle, `dbg_tx`=1.
  - A subsequent valid 'R' frame completes correctly.

Source files
------------

// File: rtl/np_dbg_pkg.sv
// Shared constants and state encodings for the serial debug bridge.
package np_dbg_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_TO = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } dbg_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAITHI
  } rx_state_t;

endpackage

// File: rtl/np_uart_phy.sv
// 8N1 byte engines: oversampling receiver with framing check and a transmitter
// that accepts the next byte in the final cycle of the previous stop bit.
module np_uart_phy
  import np_dbg_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       core_clock,
  input  logic       RST,
  input  logic       i_rx,
  output logic       o_rx_vld,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_ferr,
  output logic       o_tx,
  input  logic       i_tx_load,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_idle
);

  localparam logic [15:0] C_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST = 16'(CLK_DIV / 2 - 1);

  logic [1:0]  r_sync;
  logic        w_rx;
  rx_state_t   r_rx_state, w_rx_nxt;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic        w_bit_end, w_half;

  logic        r_tx, r_tx_busy;
  logic [8:0]  r_tx_sh;
  logic [3:0]  r_tx_bit;
  logic [15:0] r_tx_cnt;
  logic        w_tx_last;

  assign w_rx      = r_sync[1];
  assign w_bit_end = (r_rx_cnt == C_LAST);
  assign w_half    = (r_rx_cnt == H_LAST);
  assign o_rx_byte = r_rx_sh;

  always_ff @(posedge core_clock) begin
    if (!RST) begin
      r_sync     <= 2'b11;
      r_rx_state <= RX_IDLE;
    end else begin
      r_sync     <= {r_sync[0], i_rx};
      r_rx_state <= w_rx_nxt;
    end
  end

  always_comb begin
    w_rx_nxt  = r_rx_state;
    o_rx_vld  = 1'b0;
    o_rx_ferr = 1'b0;
    case (r_rx_state)
      RX_IDLE:   if (!w_rx) w_rx_nxt = RX_START;
      RX_START:  if (w_half) w_rx_nxt = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_bit_end && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP: begin
        if (w_bit_end) begin
          if (w_rx) begin
            o_rx_vld = 1'b1;
            w_rx_nxt = RX_IDLE;
          end else begin
            // a low stop bit may be a break; wait for the line to recover
            o_rx_ferr = 1'b1;
            w_rx_nxt  = RX_WAITHI;
          end
        end
      end
      RX_WAITHI: if (w_rx) w_rx_nxt = RX_IDLE;
      default:   w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge core_clock) begin
    if (!RST) begin
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      if ((r_rx_state == RX_START || r_rx_state == RX_DATA || r_rx_state == RX_STOP) &&
          w_rx_nxt == r_rx_state && !w_bit_end)
        r_rx_cnt <= r_rx_cnt + 16'd1;
      else
        r_rx_cnt <= '0;
      if (r_rx_state == RX_START)
        r_rx_bit <= '0;
      else if (r_rx_state == RX_DATA && w_bit_end) begin
        r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end
  end

  assign w_tx_last  = (r_tx_bit == 4'd9) && (r_tx_cnt == C_LAST);
  assign o_tx_ready = !r_tx_busy || w_tx_last;
  assign o_tx_idle  = !r_tx_busy;
  assign o_tx       = r_tx;

  always_ff @(posedge core_clock) begin
    if (!RST) begin
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_sh   <= '1;
      r_tx_bit  <= '0;
      r_tx_cnt  <= '0;
    end else if (i_tx_load && o_tx_ready) begin
      r_tx      <= 1'b0;
      r_tx_busy <= 1'b1;
      r_tx_sh   <= {1'b1, i_tx_data};
      r_tx_bit  <= '0;
      r_tx_cnt  <= '0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == C_LAST) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx      <= 1'b1;
        end else begin
          r_tx     <= r_tx_sh[0];
          r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
          r_tx_bit <= r_tx_bit + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/np_dbg_bridge.sv
// Serial debug bridge: parses W/R command frames, runs one iomem word
// transaction per frame and sends a status or data reply.
module np_dbg_bridge
  import np_dbg_pkg::*;
#(
  parameter int CLK_DIV     = 104,
  parameter int BUS_TIMEOUT = 255,
  parameter int FRAME_GAP   = 65535
) (
  input  logic        core_clock,
  input  logic        RST,
  input  logic        dbg_rx,
  output logic        dbg_tx,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int TO_W  = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUS_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  dbg_state_t       r_state, w_state_nxt;
  logic             r_is_wr;
  logic [1:0]       r_byte_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [31:0]      r_addr, r_wdata, r_reply;
  logic [2:0]       r_left;

  logic       w_rx_vld, w_rx_ferr, w_tx_ready, w_tx_idle, w_tx_load;
  logic [7:0] w_rx_byte;
  logic       w_last_byte, w_gap_exp, w_is_cmd, w_to_exp;

  np_uart_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .core_clock (core_clock),
    .RST        (RST),
    .i_rx       (dbg_rx),
    .o_rx_vld   (w_rx_vld),
    .o_rx_byte  (w_rx_byte),
    .o_rx_ferr  (w_rx_ferr),
    .o_tx       (dbg_tx),
    .i_tx_load  (w_tx_load),
    .i_tx_data  (r_reply[31:24]),
    .o_tx_ready (w_tx_ready),
    .o_tx_idle  (w_tx_idle)
  );

  assign w_is_cmd    = (w_rx_byte == CMD_WR) || (w_rx_byte == CMD_RD);
  assign w_last_byte = w_rx_vld && (r_byte_cnt == 2'd3);
  assign w_gap_exp   = !w_rx_vld && (r_gap_cnt == GAP_LAST);
  assign w_to_exp    = (r_to_cnt == TO_LAST);
  assign w_tx_load   = (r_state == ST_RESP) && (r_left != 3'd0) && w_tx_ready;

  assign m_valid = (r_state == ST_BUS);
  assign m_wstrb = (r_state == ST_BUS && r_is_wr) ? 4'hF : 4'h0;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign busy    = (r_state != ST_IDLE);

  always_ff @(posedge core_clock) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rx_vld && w_is_cmd) w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (w_rx_ferr || w_gap_exp) w_state_nxt = ST_IDLE;
        else if (w_last_byte)       w_state_nxt = r_is_wr ? ST_DATA : ST_BUS;
      end
      ST_DATA: begin
        if (w_rx_ferr || w_gap_exp) w_state_nxt = ST_IDLE;
        else if (w_last_byte)       w_state_nxt = ST_BUS;
      end
      // a ready landing on the expiry cycle still takes the normal path
      ST_BUS:  if (m_ready || w_to_exp) w_state_nxt = ST_RESP;
      ST_RESP: if (r_left == 3'd0 && w_tx_idle) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clock) begin
    if (!RST) begin
      r_is_wr    <= 1'b0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_to_cnt   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_reply    <= '0;
      r_left     <= '0;
    end else begin
      if (r_state != ST_BUS) r_to_cnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_rx_vld && w_is_cmd) begin
            r_is_wr    <= (w_rx_byte == CMD_WR);
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (w_rx_vld) begin
            if (r_state == ST_ADDR) r_addr  <= {r_addr[23:0], w_rx_byte};
            else                    r_wdata <= {r_wdata[23:0], w_rx_byte};
            r_byte_cnt <= (r_byte_cnt == 2'd3) ? 2'd0 : r_byte_cnt + 2'd1;
            r_gap_cnt  <= '0;
          end else if (r_gap_cnt != GAP_LAST) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        ST_BUS: begin
          if (m_ready) begin
            r_reply <= r_is_wr ? {RSP_OK, 24'h0} : m_rdata;
            r_left  <= r_is_wr ? 3'd1 : 3'd4;
          end else if (w_to_exp) begin
            r_reply <= {RSP_TO, 24'h0};
            r_left  <= 3'd1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (w_tx_load) begin
            r_reply <= {r_reply[23:0], 8'h00};
            r_left  <= r_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_np_dbg_bridge.sv
// Scoreboard bench for np_dbg_bridge: serial frames in, iomem bursts and
// serial replies checked against queued expectations.
module tb_np_dbg_bridge;

  localparam int CLK_DIV     = 8;
  localparam int BUS_TIMEOUT = 16;
  localparam int FRAME_GAP   = 400;

  logic        core_clock = 1'b0;
  logic        RST;
  logic        dbg_rx;
  logic        dbg_tx;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  always #5 core_clock = ~core_clock;

  np_dbg_bridge #(
    .CLK_DIV(CLK_DIV), .BUS_TIMEOUT(BUS_TIMEOUT), .FRAME_GAP(FRAME_GAP)
  ) dut (
    .core_clock (core_clock),
    .RST        (RST),
    .dbg_rx     (dbg_rx),
    .dbg_tx     (dbg_tx),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_wstrb    (m_wstrb),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
    bit          chk_wdata;
    bit          chk_len;
  } burst_t;

  burst_t      bus_q[$];
  logic [7:0]  rep_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_bursts = 0;
  int          rst_cnt = 0;
  int          ack_dly = 0;
  bit          never_ack = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // responder: acks in valid cycle ack_dly+1, rdata only meaningful with ready
  int vcnt = 0;
  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge core_clock);
      if (m_valid === 1'b1) begin
        vcnt++;
        m_ready = !never_ack && (vcnt == ack_dly + 1);
      end else begin
        vcnt    = 0;
        m_ready = 1'b0;
      end
      m_rdata = m_ready ? rd_val : ~rd_val;
    end
  end

  // bus monitor
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wstrb;
  int          b_len = 0;
  bit          b_stable;
  burst_t      b_exp;
  initial begin
    forever begin
      @(posedge core_clock);
      #1;
      if (m_valid === 1'b1) begin
        if (b_len == 0) begin
          b_addr = m_addr; b_wdata = m_wdata; b_wstrb = m_wstrb; b_stable = 1'b1;
        end else if (m_addr !== b_addr || m_wdata !== b_wdata || m_wstrb !== b_wstrb) begin
          b_stable = 1'b0;
        end
        b_len++;
      end else if (b_len > 0) begin
        n_bursts++;
        chk("bus_expected", 32'(bus_q.size() > 0), 32'd1);
        if (bus_q.size() > 0) begin
          b_exp = bus_q.pop_front();
          chk("bus_addr", b_addr, b_exp.addr);
          chk("bus_wstrb", 32'(b_wstrb), 32'(b_exp.wstrb));
          if (b_exp.chk_wdata) chk("bus_wdata", b_wdata, b_exp.wdata);
          if (b_exp.chk_len) chk("bus_len", b_len, b_exp.len);
          chk("bus_stable", 32'(b_stable), 32'd1);
        end
        b_len = 0;
      end
    end
  end

  // serial reply monitor; a byte cut short by reset is discarded
  logic [7:0] mon_b;
  logic       mon_stp;
  int         mon_snap;
  initial begin
    forever begin
      @(negedge dbg_tx);
      mon_snap = rst_cnt;
      repeat (CLK_DIV / 2) @(posedge core_clock);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge core_clock);
        #1 mon_b[i] = dbg_tx;
      end
      repeat (CLK_DIV) @(posedge core_clock);
      #1 mon_stp = dbg_tx;
      if (mon_snap == rst_cnt) begin
        chk("rep_stop", 32'(mon_stp), 32'd1);
        chk("rep_expected", 32'(rep_q.size() > 0), 32'd1);
        if (rep_q.size() > 0) chk("rep_byte", 32'(mon_b), 32'(rep_q.pop_front()));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int len, input bit cw, input bit cl);
    burst_t e;
    e.addr = a; e.wdata = d; e.wstrb = s; e.len = len; e.chk_wdata = cw; e.chk_len = cl;
    bus_q.push_back(e);
  endtask

  task automatic push_rep(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) rep_q.push_back(w[31-8*i -: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stp);
    @(negedge core_clock);
    dbg_rx = 1'b0;
    repeat (CLK_DIV) @(negedge core_clock);
    for (int i = 0; i < 8; i++) begin
      dbg_rx = b[i];
      repeat (CLK_DIV) @(negedge core_clock);
    end
    dbg_rx = stp;
    repeat (CLK_DIV) @(negedge core_clock);
    dbg_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(posedge core_clock);
      #1 n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_tx"},    32'(dbg_tx),  32'd1);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_wstrb"}, 32'(m_wstrb), 32'd0);
    chk({tag, "_addr"},  m_addr,       32'd0);
    chk({tag, "_wdata"}, m_wdata,      32'd0);
    chk({tag, "_busy"},  32'(busy),    32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge core_clock);
    rst_cnt++;
    RST = 1'b0;
    @(posedge core_clock);
    #1 chk_rst_outs(tag);
    @(negedge core_clock);
    RST = 1'b1;
  endtask

  int nb;
  initial begin
    RST    = 1'b0;
    dbg_rx = 1'b1;
    repeat (3) @(posedge core_clock);
    #1 chk_rst_outs("por");
    @(negedge core_clock);
    RST = 1'b1;
    repeat (10) @(negedge core_clock);

    // write, acked after 2 cycles
    ack_dly = 2;
    push_bus(32'h0300_0000, 32'h0000_00A5, 4'hF, 3, 1, 1);
    push_rep(32'h4B00_0000, 1);
    send_byte(8'h57, 1'b1);
    send_word(32'h0300_0000);
    send_word(32'h0000_00A5);
    wait_idle("wr_done");

    // read
    rd_val = 32'hDEAD_BEEF;
    push_bus(32'h0300_0000, 32'h0, 4'h0, 3, 0, 1);
    push_rep(32'hDEAD_BEEF, 4);
    send_byte(8'h52, 1'b1);
    send_word(32'h0300_0000);
    wait_idle("rd_done");

    // timeout on a write
    never_ack = 1;
    push_bus(32'h0000_1000, 32'h1234_5678, 4'hF, BUS_TIMEOUT, 1, 1);
    push_rep(32'h5400_0000, 1);
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_1000);
    send_word(32'h1234_5678);
    wait_idle("to_done");
    never_ack = 0;

    // ready in the expiry cycle wins over timeout
    ack_dly = BUS_TIMEOUT - 1;
    rd_val  = 32'hCAFE_F00D;
    push_bus(32'h0400_0000, 32'h0, 4'h0, BUS_TIMEOUT, 0, 1);
    push_rep(32'hCAFE_F00D, 4);
    send_byte(8'h52, 1'b1);
    send_word(32'h0400_0000);
    wait_idle("exp_done");

    // unknown command
    nb = n_bursts;
    send_byte(8'h41, 1'b1);
    repeat (20) @(posedge core_clock);
    #1 chk("bad_cmd_busy", 32'(busy), 32'd0);
    chk("bad_cmd_nobus", n_bursts, nb);

    // framing error in second address byte
    send_byte(8'h52, 1'b1);
    #1 chk("ferr_busy_hi", 32'(busy), 32'd1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (20) @(posedge core_clock);
    #1 chk("ferr_busy", 32'(busy), 32'd0);
    chk("ferr_nobus", n_bursts, nb);

    // inter-byte gap after two address bytes
    send_byte(8'h52, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    #1 chk("gap_busy_hi", 32'(busy), 32'd1);
    repeat (FRAME_GAP + 50) @(posedge core_clock);
    #1 chk("gap_busy", 32'(busy), 32'd0);
    chk("gap_nobus", n_bursts, nb);

    // reset while the bus cycle is outstanding
    never_ack = 1;
    push_bus(32'h0500_0000, 32'h0, 4'h0, 0, 0, 0);
    send_byte(8'h52, 1'b1);
    send_word(32'h0500_0000);
    for (int i = 0; i < 200 && m_valid !== 1'b1; i++) @(posedge core_clock);
    #1 chk("rst_bus_seen", 32'(m_valid), 32'd1);
    repeat (3) @(posedge core_clock);
    pulse_reset("rst_bus");
    never_ack = 0;
    repeat (20) @(negedge core_clock);

    // reset in the middle of the reply byte
    ack_dly = 0;
    push_bus(32'h0600_0000, 32'h0000_0001, 4'hF, 1, 1, 1);
    send_byte(8'h57, 1'b1);
    send_word(32'h0600_0000);
    send_word(32'h0000_0001);
    for (int i = 0; i < 3000 && dbg_tx !== 1'b0; i++) begin
      @(posedge core_clock);
      #1;
    end
    chk("rst_tx_started", 32'(dbg_tx), 32'd0);
    repeat (3 * CLK_DIV) @(posedge core_clock);
    pulse_reset("rst_tx");
    repeat (100) @(negedge core_clock);

    // clean read after resets
    ack_dly = 1;
    rd_val  = 32'h0BAD_CAFE;
    push_bus(32'h0300_0000, 32'h0, 4'h0, 2, 0, 1);
    push_rep(32'h0BAD_CAFE, 4);
    send_byte(8'h52, 1'b1);
    send_word(32'h0300_0000);
    wait_idle("post_rst_done");

    repeat (50) @(posedge core_clock);
    #1 chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("rep_q_drained", rep_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
